// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD image controller.
//   cmd_e   : host command codes (13-15 are unassigned and behave as no-ops)
//   state_e : controller FSM states
//   pix_idx : linear frame-buffer index of (row, col) in an n-wide image
package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE  = 4'd0,
        CMD_UP     = 4'd1,
        CMD_DOWN   = 4'd2,
        CMD_LEFT   = 4'd3,
        CMD_RIGHT  = 4'd4,
        CMD_AVG    = 4'd5,
        CMD_MIRX   = 4'd6,
        CMD_MIRY   = 4'd7,
        CMD_ROTCCW = 4'd8,
        CMD_ROTCW  = 4'd9,
        CMD_MAX    = 4'd10,
        CMD_MIN    = 4'd11,
        CMD_CENTER = 4'd12
    } cmd_e;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_LOAD_LAST,
        ST_READY,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_e;

    // n is always a power of two, so the multiply reduces to a shift.
    function automatic logic [31:0] pix_idx(input logic [31:0] row,
                                            input logic [31:0] col,
                                            input logic [31:0] n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/lcd_blk_alu.sv
// Combinational 2x2 block operator.
//   tl, tr, bl, br         : current block pixels (top-left .. bottom-right)
//   cmd                    : command code being executed
//   tl_n, tr_n, bl_n, br_n : block pixels after the operation
// Codes that do not touch pixel data pass the block through unchanged.
module lcd_blk_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] tl,
    input  logic [DW-1:0] tr,
    input  logic [DW-1:0] bl,
    input  logic [DW-1:0] br,
    input  logic [3:0]    cmd,
    output logic [DW-1:0] tl_n,
    output logic [DW-1:0] tr_n,
    output logic [DW-1:0] bl_n,
    output logic [DW-1:0] br_n
);

    logic [DW+1:0] sum;
    logic [DW-1:0] avg;
    logic [DW-1:0] mx_t;
    logic [DW-1:0] mx_b;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn_t;
    logic [DW-1:0] mn_b;
    logic [DW-1:0] mn;

    always_comb begin
        // Two guard bits hold the four-pixel sum without overflow.
        sum  = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
        avg  = sum[DW+1:2];
        mx_t = (tl > tr) ? tl : tr;
        mx_b = (bl > br) ? bl : br;
        mx   = (mx_t > mx_b) ? mx_t : mx_b;
        mn_t = (tl < tr) ? tl : tr;
        mn_b = (bl < br) ? bl : br;
        mn   = (mn_t < mn_b) ? mn_t : mn_b;
    end

    always_comb begin
        tl_n = tl;
        tr_n = tr;
        bl_n = bl;
        br_n = br;
        case (cmd)
            CMD_AVG: begin
                tl_n = avg;
                tr_n = avg;
                bl_n = avg;
                br_n = avg;
            end
            CMD_MIRX: begin
                tl_n = bl;
                bl_n = tl;
                tr_n = br;
                br_n = tr;
            end
            CMD_MIRY: begin
                tl_n = tr;
                tr_n = tl;
                bl_n = br;
                br_n = bl;
            end
            CMD_ROTCCW: begin
                tl_n = tr;
                tr_n = br;
                br_n = bl;
                bl_n = tl;
            end
            CMD_ROTCW: begin
                tr_n = tl;
                br_n = tr;
                bl_n = br;
                tl_n = bl;
            end
            CMD_MAX: begin
                tl_n = mx;
                tr_n = mx;
                bl_n = mx;
                br_n = mx;
            end
            CMD_MIN: begin
                tl_n = mn;
                tr_n = mn;
                bl_n = mn;
                br_n = mn;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// LCD image controller: loads an N x N image from IROM, edits the 2x2 block
// around a movable op point on host command, and dumps the frame to IRB.
//   clk, reset (active-low, async)
//   cmd, cmd_valid         : host command, taken when busy is low
//   IROM_Q/IROM_EN/IROM_A  : image ROM port (EN active-low, 1-cycle latency)
//   IRB_RW/IRB_D/IRB_A     : result buffer write port (RW=0 writes)
//   busy, done             : handshake; done pulses once per finished WRITE
//
// state        | meaning
// ST_LOAD      | stream IROM addresses, capture data one cycle behind
// ST_LOAD_LAST | IROM disabled, capture the final pixel
// ST_READY     | idle, accept a command
// ST_EXEC      | one-cycle block / op-point update
// ST_WRITE     | stream the frame to IRB
// ST_DONE      | done pulse; accepts a command exactly like ST_READY
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 8,
    parameter int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int            XW    = $clog2(N);
    localparam int            NP    = N * N;
    localparam logic [AW-1:0] LAST  = AW'(NP - 1);
    localparam logic [XW-1:0] MID   = XW'(N / 2);
    localparam logic [XW-1:0] X_MIN = XW'(1);
    localparam logic [XW-1:0] X_MAX = XW'(N - 1);

    state_e        state;
    logic [3:0]    cmd_q;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [DW-1:0] frame [NP];

    logic [XW-1:0] xm1;
    logic [XW-1:0] ym1;
    logic [AW-1:0] i_tl;
    logic [AW-1:0] i_tr;
    logic [AW-1:0] i_bl;
    logic [AW-1:0] i_br;
    logic [DW-1:0] tl_n;
    logic [DW-1:0] tr_n;
    logic [DW-1:0] bl_n;
    logic [DW-1:0] br_n;

    // x and y never drop below 1, so these cannot wrap.
    assign xm1  = x - XW'(1);
    assign ym1  = y - XW'(1);
    assign i_tl = AW'(pix_idx(32'(ym1), 32'(xm1), N));
    assign i_tr = AW'(pix_idx(32'(ym1), 32'(x),   N));
    assign i_bl = AW'(pix_idx(32'(y),   32'(xm1), N));
    assign i_br = AW'(pix_idx(32'(y),   32'(x),   N));

    lcd_blk_alu #(.DW(DW)) u_alu (
        .tl   (frame[i_tl]),
        .tr   (frame[i_tr]),
        .bl   (frame[i_bl]),
        .br   (frame[i_br]),
        .cmd  (cmd_q),
        .tl_n (tl_n),
        .tr_n (tr_n),
        .bl_n (bl_n),
        .br_n (br_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            IROM_EN <= 1'b1;
            IROM_A  <= '0;
            IRB_RW  <= 1'b1;
            IRB_A   <= '0;
            IRB_D   <= '0;
            x       <= MID;
            y       <= MID;
            cmd_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    // First cycle after reset only enables the ROM at address 0.
                    if (IROM_EN) begin
                        IROM_EN <= 1'b0;
                    end else if (IROM_A == LAST) begin
                        IROM_EN <= 1'b1;
                        state   <= ST_LOAD_LAST;
                    end else begin
                        IROM_A <= IROM_A + AW'(1);
                    end
                end
                ST_LOAD_LAST: begin
                    IROM_A <= '0;
                    busy   <= 1'b0;
                    state  <= ST_READY;
                end
                ST_READY, ST_DONE: begin
                    state <= ST_READY;
                    if (cmd_valid) begin
                        cmd_q <= cmd;
                        busy  <= 1'b1;
                        if (cmd == CMD_WRITE) begin
                            state  <= ST_WRITE;
                            IRB_RW <= 1'b0;
                            IRB_A  <= '0;
                            IRB_D  <= frame[AW'(0)];
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    case (cmd_q)
                        CMD_UP:     if (y > X_MIN) y <= y - XW'(1);
                        CMD_DOWN:   if (y < X_MAX) y <= y + XW'(1);
                        CMD_LEFT:   if (x > X_MIN) x <= x - XW'(1);
                        CMD_RIGHT:  if (x < X_MAX) x <= x + XW'(1);
                        CMD_CENTER: begin
                            x <= MID;
                            y <= MID;
                        end
                        default: ;
                    endcase
                    busy  <= 1'b0;
                    state <= ST_READY;
                end
                ST_WRITE: begin
                    if (IRB_A == LAST) begin
                        IRB_RW <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        IRB_A <= IRB_A + AW'(1);
                        IRB_D <= frame[IRB_A + AW'(1)];
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Frame buffer has no reset: its contents are meaningless until reloaded.
    // ROM data trails the address by one cycle, hence the IROM_A-1 write index.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && !IROM_EN && IROM_A != '0) begin
            frame[IROM_A - AW'(1)] <= IROM_Q;
        end else if (state == ST_LOAD_LAST) begin
            frame[IROM_A] <= IROM_Q;
        end else if (state == ST_EXEC) begin
            frame[i_tl] <= tl_n;
            frame[i_tr] <= tr_n;
            frame[i_bl] <= bl_n;
            frame[i_br] <= br_n;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen (DW=8, N=8). A registered ROM model feeds
// the load, an IRB model captures writes, and every frame dump is compared
// against a hand-maintained expected image.
module tb_lcd_ctrl_gen;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 6;
    localparam int NP = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    cmd = 4'd0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] IROM_Q = '0;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom     [NP];
    logic [DW-1:0] irb     [NP];
    logic [DW-1:0] exp_img [NP];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    always #5 clk = ~clk;

    lcd_ctrl_gen #(.DW(DW), .N(N), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_Q    (IROM_Q),
        .IROM_EN   (IROM_EN),
        .IROM_A    (IROM_A),
        .IRB_RW    (IRB_RW),
        .IRB_D     (IRB_D),
        .IRB_A     (IRB_A),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        if (!IROM_EN) IROM_Q <= rom[IROM_A];
    end

    always @(posedge clk) begin
        if (!IRB_RW) begin
            irb[IRB_A] <= IRB_D;
            wr_cnt     <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < NP; i++)
            check($sformatf("%s_irb%0d", tag, i), 32'(irb[i]), 32'(exp_img[i]));
    endtask

    // Caller must be on a negedge.
    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("idle_before_cmd", 32'(busy), 0);
    endtask

    // Assert reset now, check reset outputs, release one unit before a
    // rising edge and count cycles after that edge until busy falls.
    task automatic reset_and_load();
        int t;
        reset = 1'b0;
        #1;
        check("rst_busy",    32'(busy), 1);
        check("rst_done",    32'(done), 0);
        check("rst_irom_en", 32'(IROM_EN), 1);
        check("rst_irb_rw",  32'(IRB_RW), 1);
        check("rst_irom_a",  32'(IROM_A), 0);
        check("rst_irb_a",   32'(IRB_A), 0);
        check("rst_irb_d",   32'(IRB_D), 0);
        repeat (2) @(negedge clk);
        #4;
        reset = 1'b1;
        @(posedge clk);
        #1;
        t = 0;
        while (busy && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("load_latency", 32'(t), 65);
    endtask

    task automatic send_cmd(input logic [3:0] c);
        int t;
        int d0;
        int w0;
        @(negedge clk);
        wait_idle();
        d0 = done_cnt;
        w0 = wr_cnt;
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check($sformatf("busy_after_cmd%0d", c), 32'(busy), 1);
        t = 0;
        while (busy && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check($sformatf("latency_cmd%0d", c), 32'(t), (c == 4'd0) ? 64 : 1);
        @(posedge clk);
        #1;
        check($sformatf("done_pulses_cmd%0d", c), 32'(done_cnt - d0), (c == 4'd0) ? 1 : 0);
        check($sformatf("irb_writes_cmd%0d", c), 32'(wr_cnt - w0), (c == 4'd0) ? 64 : 0);
    endtask

    initial begin
        int t;
        int d0;
        int w0;

        for (int i = 0; i < NP; i++) begin
            rom[i]     = DW'(i);
            exp_img[i] = DW'(i);
            irb[i]     = '0;
        end

        #2;
        reset_and_load();
        send_cmd(4'd0);
        check_frame("load");

        // AVG at centre: 27,28,35,36 -> floor(126/4) = 31
        send_cmd(4'd5);
        exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
        send_cmd(4'd0);
        check_frame("avg");

        // Clamp at (1,1), ROTCW on 0,1,8,9
        repeat (5) send_cmd(4'd1);
        repeat (5) send_cmd(4'd3);
        send_cmd(4'd9);
        exp_img[0] = 8; exp_img[1] = 0; exp_img[8] = 9; exp_img[9] = 1;
        // (x,y)=(2,1): block 1,2,9,10 = 0,2,1,10 -> ROTCCW
        send_cmd(4'd4);
        send_cmd(4'd8);
        exp_img[1] = 2; exp_img[2] = 10; exp_img[10] = 1; exp_img[9] = 0;
        send_cmd(4'd13);
        send_cmd(4'd15);
        send_cmd(4'd0);
        check_frame("rot");

        // Clamp at (7,7), MIRY on 54,55,62,63
        send_cmd(4'd12);
        repeat (5) send_cmd(4'd2);
        repeat (5) send_cmd(4'd4);
        send_cmd(4'd7);
        exp_img[54] = 55; exp_img[55] = 54; exp_img[62] = 63; exp_img[63] = 62;
        // Recentre, UP to (4,3): block 19,20,27,28 = 19,20,31,31 -> 25
        send_cmd(4'd12);
        send_cmd(4'd1);
        send_cmd(4'd5);
        exp_img[19] = 25; exp_img[20] = 25; exp_img[27] = 25; exp_img[28] = 25;
        send_cmd(4'd2);
        send_cmd(4'd0);
        check_frame("clamp");

        // cmd_valid held high through busy: MIRX offered mid-write must be
        // ignored, and the WRITE still offered at done re-arms immediately.
        @(negedge clk);
        wait_idle();
        d0 = done_cnt;
        w0 = wr_cnt;
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_accept", 32'(busy), 1);
        cmd = 4'd6;
        repeat (30) @(posedge clk);
        #1;
        check("b2b_still_busy", 32'(busy), 1);
        cmd = 4'd0;
        t = 0;
        while (!done && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("b2b_done1", 32'(done), 1);
        check("b2b_busy_at_done", 32'(busy), 0);
        check_frame("b2b_first");
        @(posedge clk);
        #1;
        check("b2b_second_accept", 32'(busy), 1);
        cmd_valid = 1'b0;
        t = 0;
        while (busy && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        check("b2b_done_pulses", 32'(done_cnt - d0), 2);
        check("b2b_writes", 32'(wr_cnt - w0), 128);
        check_frame("b2b_second");

        // New image, reset in the middle of a WRITE
        rom[27] = 200; rom[28] = 10; rom[35] = 255; rom[36] = 0;
        @(negedge clk);
        wait_idle();
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("mid_write_rw", 32'(IRB_RW), 0);
        reset_and_load();
        for (int i = 0; i < NP; i++) exp_img[i] = rom[i];
        send_cmd(4'd0);
        check_frame("reload");

        // Block 27,28,35,36 = 200,10,255,0
        send_cmd(4'd6);
        exp_img[27] = 255; exp_img[28] = 0; exp_img[35] = 200; exp_img[36] = 10;
        send_cmd(4'd0);
        check_frame("mirx");
        send_cmd(4'd7);
        send_cmd(4'd10);
        exp_img[27] = 255; exp_img[28] = 255; exp_img[35] = 255; exp_img[36] = 255;
        send_cmd(4'd0);
        check_frame("max");

        @(negedge clk);
        reset_and_load();
        for (int i = 0; i < NP; i++) exp_img[i] = rom[i];
        send_cmd(4'd11);
        exp_img[27] = 0; exp_img[28] = 0; exp_img[35] = 0; exp_img[36] = 0;
        send_cmd(4'd0);
        check_frame("min");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl_gen.md
Name: lcd_ctrl_gen

Overview:
- Parametrised successor of the LCD image controller.
- Loads an N×N image from IROM into an internal frame buffer, then applies host commands to the 2×2 block around a movable operation point.
- On command, writes the frame to IRB.
- Beyond the original: parametrised width and size, rotate, max and min ops, an op-point recentre command, and repeatable writes.

Parameters:
- DW, 8: pixel data width.
- N, 8: image side length; power of 2, minimum 4.
- AW, $clog2(N*N): IROM and IRB address width.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- cmd  in  4: command code, sampled when cmd_valid=1 and busy=0.
- cmd_valid  in  1: command strobe.
- IROM_Q  in  DW: IROM read data; valid the cycle after the address is presented with IROM_EN=0.
- IROM_EN  out  1: IROM chip enable, active-low.
- IROM_A  out  AW: IROM address.
- IRB_RW  out  1: IRB write enable, active-low (0 = write).
- IRB_D  out  DW: IRB write data.
- IRB_A  out  AW: IRB address.
- busy  out  1: controller cannot accept a command.
- done  out  1: one-cycle pulse when a WRITE completes.

Behaviour:
- Reset values: busy=1, done=0, IROM_EN=1, IRB_RW=1, IROM_A=0, IRB_A=0, IRB_D=0, op point (x,y)=(N/2,N/2), state LOAD.
- Reset mid-operation aborts immediately and restarts LOAD once reset is released. Buffer contents are don't-care until reloaded.
- Pixel index = row*N + col.
- Block around the op point:
  - TL = (y-1, x-1), TR = (y-1, x)
  - BL = (y, x-1), BR = (y, x)
  - x and y are always in 1..N-1.
- LOAD:
  - IROM_EN=0; IROM_A steps 0..N*N-1, one per cycle.
  - Data captured into buf[IROM_A delayed by 1].
  - After the last address, state LOAD_LAST captures the final pixel with IROM_EN=1.
  - Then READY with busy=0.
  - busy falls N*N+1 cycles after reset release.
- READY:
  - cmd_valid=1 at a rising edge latches cmd and sets busy=1 on the next cycle.
  - cmd_valid is ignored while busy=1.
- EXEC, non-write commands:
  - Exactly one cycle; buffer and op point update at the end of EXEC.
  - busy=1 for that single cycle, then READY.
- Command codes:
  - 0 WRITE.
  - 1 UP: y=max(y-1,1). 2 DOWN: y=min(y+1,N-1). 3 LEFT: x=max(x-1,1). 4 RIGHT: x=min(x+1,N-1). At a boundary the op point is unchanged and the command still takes one cycle.
  - 5 AVG: all four block pixels = floor(sum/4). Sum is held in DW+2 bits; no overflow.
  - 6 MIRX: swap TL↔BL and TR↔BR.
  - 7 MIRY: swap TL↔TR and BL↔BR.
  - 8 ROTCCW: TL←TR, TR←BR, BR←BL, BL←TL. 9 ROTCW: the inverse of ROTCCW.
  - 10 MAX: all four pixels = max of the four. 11 MIN: all four pixels = min of the four.
  - 12 CENTER: (x,y)=(N/2,N/2).
  - 13-15: no-op, one-cycle busy.
- WRITE:
  - IRB_RW=0 for N*N consecutive cycles; IRB_A steps 0..N*N-1 with IRB_D=buf[IRB_A].
  - Next cycle: IRB_RW=1, done=1 for one cycle, busy=0, state READY.
  - Further commands and repeated WRITEs are legal.
- Outputs are registered; IRB_D/IRB_A/IRB_RW change only on rising clk.
- State machine: LOAD → LOAD_LAST → READY ↔ EXEC / WRITE → DONE → READY.

Decomposition:
- Package lcd_ctrl_pkg:
  - cmd_e enum (codes 0-12).
  - state_e enum (LOAD, LOAD_LAST, READY, EXEC, WRITE, DONE).
  - Function for block index computation.
- One sub-module, lcd_blk_alu:
  - Combinational.
  - Inputs: four DW pixels and cmd. Outputs: four new pixels.
  - Implements AVG, MIRX, MIRY, ROT*, MAX, MIN.
  - Pass-through for all other codes.

Test Plan:
- Reset release with IROM[i]=i, then WRITE (0) → busy low after 65 cycles; IRB[i]=i for i=0..63; done pulses once.
- AVG at centre (block values 27,28,35,36) then WRITE → IRB[27], IRB[28], IRB[35], IRB[36] all = 31.
- 5× UP then 5× LEFT then ROTCW then WRITE → op point clamps at (1,1). Block 0,1,8,9 becomes TL=8, TR=0, BR=1, BL=9.
- MIRX, MIRY, MAX, MIN on pixels 27,28,35,36 = 200,10,255,0 → MIRX gives 255,0,200,10; MAX sets all four to 255; MIN sets all four to 0.
- Assert reset during WRITE at cycle 20 → IRB_RW=1 immediately; reload; busy=1 for 65 cycles; a subsequent WRITE reproduces IROM.
- cmd_valid held high during busy, plus back-to-back WRITEs → only commands with busy=0 are accepted; two done pulses with identical IRB contents.
